// File: rtl/core_types_pkg.sv
// Shared core types for fetch, instruction buffer and decode.
// Holds the instruction record that moves between these stages and the
// default buffer geometry. Fetch and decode reuse the same constants.
package core_types;

    localparam int INSTR_W     = 32;
    localparam int IB_DEPTH    = 8;  // entry count, power of two, >= 4
    localparam int IB_IF_WIDTH = 2;  // max instructions pushed per cycle
    localparam int IB_ID_WIDTH = 2;  // max instructions popped per cycle

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
    } instr_buffer_info_t;

endpackage

// File: rtl/instr_buffer_lzc_accept.sv
// lzc_accept: counts consecutive ones starting from bit 0.
// It computes the pop count from the accept bits after they are masked
// with the output valid bits. Counting stops at the first zero.
//   bits_i : accept AND valid, bit 0 is the oldest slot
//   ones_o : number of leading ones (0..W)
module lzc_accept #(
    parameter  int W  = 2,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits_i,
    output logic [CW-1:0] ones_o
);

    logic run;

    always_comb begin
        ones_o = '0;
        run    = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (run && bits_i[i]) begin
                ones_o = ones_o + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_buffer.sv
// instr_buffer: in-order circular instruction FIFO between fetch and decode.
// Each cycle it accepts up to IF_WIDTH instructions. Invalid fetch slots are
// dropped, so the stored entries have no gaps. Each cycle it presents up to
// ID_WIDTH of the oldest entries to decode.
//   clk                 : clock
//   rst_n               : asynchronous active-low reset (clears pointers/count)
//   flush_i             : drop all stored and same-cycle incoming instructions
//   frontend_instr_i    : fetched instructions, per-slot valid
//   frontend_stallreq_o : buffer cannot take a full fetch group; push ignored
//   backend_accept_i    : per-slot pop acknowledge from decode
//   backend_instr_o     : oldest entries, slot 0 oldest, per-slot valid
module instr_buffer
    import core_types::*;
#(
    parameter int DEPTH    = IB_DEPTH,
    parameter int IF_WIDTH = IB_IF_WIDTH,
    parameter int ID_WIDTH = IB_ID_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush_i,
    input  instr_buffer_info_t [IF_WIDTH-1:0]  frontend_instr_i,
    output logic                               frontend_stallreq_o,
    input  logic [ID_WIDTH-1:0]                backend_accept_i,
    output instr_buffer_info_t [ID_WIDTH-1:0]  backend_instr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int POP_W = $clog2(ID_WIDTH + 1);

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    // Payload storage is deliberately unreset; the count alone qualifies it.
    instr_buffer_info_t mem [DEPTH];

    logic [IF_WIDTH-1:0] wr_en;
    logic [PTR_W-1:0]    wr_idx [IF_WIDTH];
    logic [CNT_W-1:0]    push_cnt;
    logic [ID_WIDTH-1:0] out_valid;
    logic [POP_W-1:0]    pop_cnt;

    // Stall comes only from the registered count. Same-cycle pops are not
    // taken into account, so no combinational path runs from decode to fetch.
    assign frontend_stallreq_o = (count > CNT_W'(DEPTH - IF_WIDTH));

    // Compaction: the k-th valid fetch slot goes to tail+k.
    always_comb begin
        wr_en    = '0;
        wr_idx   = '{default: '0};
        push_cnt = '0;
        for (int j = 0; j < IF_WIDTH; j++) begin
            wr_idx[j] = tail + push_cnt[PTR_W-1:0];
            wr_en[j]  = frontend_instr_i[j].valid && !frontend_stallreq_o && !flush_i;
            if (wr_en[j]) begin
                push_cnt = push_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < IF_WIDTH; j++) begin
            if (wr_en[j]) begin
                mem[wr_idx[j]] <= frontend_instr_i[j];
            end
        end
    end

    // Outputs read only registered storage. A push becomes visible in the
    // next cycle at the earliest, because there is no bypass.
    always_comb begin
        backend_instr_o = '0;
        out_valid       = '0;
        for (int i = 0; i < ID_WIDTH; i++) begin
            out_valid[i]             = (CNT_W'(i) < count);
            backend_instr_o[i]       = mem[head + PTR_W'(i)];
            backend_instr_o[i].valid = out_valid[i];
        end
    end

    lzc_accept #(
        .W (ID_WIDTH)
    ) u_lzc_accept (
        .bits_i (backend_accept_i & out_valid),
        .ones_o (pop_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_cnt);
            tail  <= tail + push_cnt[PTR_W-1:0];
            count <= count + push_cnt - CNT_W'(pop_cnt);
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
module tb_instr_buffer;
    import core_types::*;

    logic                           clk;
    logic                           rst_n;
    logic                           flush_i;
    instr_buffer_info_t [1:0]       fe;
    logic                           stall;
    logic [1:0]                     acc;
    instr_buffer_info_t [1:0]       be;

    int checks = 0;
    int errors = 0;

    instr_buffer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush_i             (flush_i),
        .frontend_instr_i    (fe),
        .frontend_stallreq_o (stall),
        .backend_accept_i    (acc),
        .backend_instr_o     (be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] i0,
                         input logic v1, input logic [31:0] i1,
                         input logic [1:0] a, input logic fl);
        fe[0].valid = v0;
        fe[0].instr = i0;
        fe[1].valid = v1;
        fe[1].instr = i1;
        acc         = a;
        flush_i     = fl;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cyc(); cyc();
        chk("rst_v0", 32'(be[0].valid), 32'd0);
        chk("rst_v1", 32'(be[1].valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        cyc();

        // compaction: {0,1} then {1,1}
        drive(1'b0, 32'hDEAD, 1'b1, 32'h5000_0000, 2'b00, 1'b0);
        #1;
        chk("nobypass_v0", 32'(be[0].valid), 32'd0);
        cyc();
        chk("cmp1_cnt", 32'(dut.count), 32'd1);
        chk("cmp1_o0", be[0].instr, 32'h5000_0000);
        chk("cmp1_v1", 32'(be[1].valid), 32'd0);
        drive(1'b1, 32'h11, 1'b1, 32'h22, 2'b00, 1'b0);
        cyc();
        chk("cmp2_cnt", 32'(dut.count), 32'd3);
        chk("cmp2_o0", be[0].instr, 32'h5000_0000);
        chk("cmp2_o1", be[1].instr, 32'h11);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b01, 1'b0);
        cyc();
        chk("cmp3_o0", be[0].instr, 32'h11);
        chk("cmp3_o1", be[1].instr, 32'h22);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 1'b0);
        cyc();
        chk("cmp4_cnt", 32'(dut.count), 32'd0);

        // accept gating
        drive(1'b1, 32'hA1, 1'b1, 32'hA2, 2'b00, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b10, 1'b0);
        cyc();
        chk("gate10_cnt", 32'(dut.count), 32'd2);
        chk("gate10_o0", be[0].instr, 32'hA1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b01, 1'b0);
        cyc();
        chk("gate01_o0", be[0].instr, 32'hA2);
        chk("gate01_v1", 32'(be[1].valid), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 1'b0);
        cyc();
        chk("gate11_cnt", 32'(dut.count), 32'd0);

        // walk head to 6, then wrap
        drive(1'b1, 32'hB0, 1'b0, 32'h0, 2'b00, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b01, 1'b0);
        cyc();
        drive(1'b1, 32'hC0, 1'b1, 32'hC1, 2'b00, 1'b0);
        cyc();
        chk("wrap_head0", 32'(dut.head), 32'd6);
        chk("wrap_cnt0", 32'(dut.count), 32'd2);
        chk("wrap_o0", be[0].instr, 32'hC0);
        chk("wrap_o1", be[1].instr, 32'hC1);
        drive(1'b1, 32'hD0, 1'b1, 32'hD1, 2'b11, 1'b0);
        cyc();
        chk("wrap_head1", 32'(dut.head), 32'd0);
        chk("wrap_tail1", 32'(dut.tail), 32'd2);
        chk("wrap_cnt1", 32'(dut.count), 32'd2);
        chk("wrap_o0b", be[0].instr, 32'hD0);
        chk("wrap_o1b", be[1].instr, 32'hD1);

        // full / stall
        drive(1'b1, 32'hE0, 1'b1, 32'hE1, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 32'hE2, 1'b1, 32'hE3, 2'b00, 1'b0);
        cyc();
        chk("full6_stall", 32'(stall), 32'd0);
        drive(1'b1, 32'hE4, 1'b0, 32'h0, 2'b00, 1'b0);
        cyc();
        chk("full7_cnt", 32'(dut.count), 32'd7);
        chk("full7_stall", 32'(stall), 32'd1);
        drive(1'b1, 32'hF0, 1'b1, 32'hF1, 2'b00, 1'b0);
        cyc();
        chk("full_hold_cnt", 32'(dut.count), 32'd7);
        drive(1'b1, 32'hF0, 1'b1, 32'hF1, 2'b01, 1'b0);
        cyc();
        chk("full_pop_cnt", 32'(dut.count), 32'd6);
        chk("full_pop_stall", 32'(stall), 32'd0);
        chk("full_pop_o0", be[0].instr, 32'hD1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 1'b0);
        cyc();
        chk("pre_fl_cnt", 32'(dut.count), 32'd4);
        chk("pre_fl_o0", be[0].instr, 32'hE1);
        chk("pre_fl_o1", be[1].instr, 32'hE2);

        // flush with concurrent push and accept
        drive(1'b1, 32'h77, 1'b1, 32'h78, 2'b11, 1'b1);
        cyc();
        idle();
        #1;
        chk("fl_v0", 32'(be[0].valid), 32'd0);
        chk("fl_v1", 32'(be[1].valid), 32'd0);
        chk("fl_cnt", 32'(dut.count), 32'd0);
        cyc();
        chk("fl_after_v0", 32'(be[0].valid), 32'd0);
        chk("fl_tail", 32'(dut.tail), 32'd0);

        // reset mid-traffic with 5 entries
        drive(1'b1, 32'h31, 1'b1, 32'h32, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 32'h33, 1'b1, 32'h34, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 32'h35, 1'b0, 32'h0, 2'b00, 1'b0);
        cyc();
        idle();
        chk("rst5_cnt", 32'(dut.count), 32'd5);
        chk("rst5_v1", 32'(be[1].valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_v0", 32'(be[0].valid), 32'd0);
        chk("arst_v1", 32'(be[1].valid), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 32'h41, 1'b1, 32'h42, 2'b00, 1'b0);
        #1;
        chk("post_rst_v0", 32'(be[0].valid), 32'd0);
        cyc();
        idle();
        chk("post_rst_o0", be[0].instr, 32'h41);
        chk("post_rst_o1", be[1].instr, 32'h42);
        chk("post_rst_v1", 32'(be[1].valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_buffer.md
INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, >=4).
REQ-002 SHALL have parameter IF_WIDTH, default 2, max instructions pushed per cycle.
REQ-003 SHALL have parameter ID_WIDTH, default 2, max instructions popped per cycle.
REQ-004 SHALL have port clk  input  1  the single clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush_i  input  1  discard all buffered and incoming instructions.
REQ-007 SHALL have port frontend_instr_i  input  IF_WIDTH x instr_buffer_info_t  fetched instructions; each element carries its own valid bit.
REQ-008 SHALL have port frontend_stallreq_o  output  1  frontend must hold; pushes in this cycle are ignored.
REQ-009 SHALL have port backend_accept_i  input  ID_WIDTH  per-slot pop acknowledge from decode.
REQ-010 SHALL have port backend_instr_o  output  ID_WIDTH x instr_buffer_info_t  oldest entries, slot 0 oldest; each element carries a valid bit.

Function
REQ-011 SHALL be an in-order circular FIFO of DEPTH entries, tracked by head pointer, tail pointer and a registered count of width clog2(DEPTH)+1.
REQ-012 SHALL drive frontend_stallreq_o combinationally as count > DEPTH-IF_WIDTH, from the registered count only, with no dependence on same-cycle pops.
REQ-013 SHALL, when frontend_stallreq_o=0 and flush_i=0, write valid frontend slots in ascending index order to consecutive entries from tail, skipping invalid slots (compaction), and advance tail by the number written.
REQ-014 SHALL drive backend_instr_o[i] combinationally from entry head+i (mod DEPTH), with valid[i]=1 only when i<count.
REQ-015 SHALL pop the number of leading consecutive ones in backend_accept_i that coincide with valid output slots; accept bits after the first zero or on invalid slots are ignored.
REQ-016 SHALL update count as count + pushed - popped when push and pop occur in the same cycle.
REQ-017 SHALL make a pushed instruction visible at backend_instr_o no earlier than the cycle after the push (1-cycle minimum latency, no bypass).
REQ-018 SHALL wrap head and tail modulo DEPTH without losing or duplicating entries.
REQ-019 SHALL, on flush_i=1, set head=tail=count=0 at the next edge, drop that cycle's push and pop, and hold valid outputs at 0 in the following cycle.
REQ-020 SHALL never overflow: count <= DEPTH always holds, since stall blocks any push that could exceed capacity.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously clear head, tail and count to 0, so that every backend_instr_o valid bit is 0 and frontend_stallreq_o is 0.
REQ-022 SHALL leave entry payload storage unreset; payload is ignored while the corresponding valid bit is 0.
REQ-023 SHALL resume normal operation on the first clock edge after rst_n rises; reset asserted mid-operation discards all contents.

Structure
REQ-024 SHALL take instr_buffer_info_t from core_types; DEPTH, IF_WIDTH and ID_WIDTH defaults SHALL be constants in core_types for reuse by fetch and decode.
REQ-025 SHALL contain no sub-modules except an optional leading-ones counter, lzc_accept, used for the pop count.

Verification
REQ-026 SHALL verify reset: rst_n=0 mid-traffic with count=5 -> all output valids 0 and stallreq 0 immediately; after release, the first push of 2 appears one cycle later.
REQ-027 SHALL verify compaction: push valid={0,1} with instr 0x50000000, then {1,1} -> outputs show 0x50000000 first, then the two new instructions in order, count=3.
REQ-028 SHALL verify full/stall: 7 entries held, no accepts -> stallreq=1, push ignored, count stays 7; accept slot 0 -> count 6, stallreq drops in the next cycle.
REQ-029 SHALL verify simultaneous push/pop with wrap: head=6, count=2, push 2 and accept 2 -> head=0, tail=2, count=2, order preserved.
REQ-030 SHALL verify accept gating: backend_accept_i=2'b10 with 2 valid -> no pop; 2'b11 with 1 valid -> pop 1.
REQ-031 SHALL verify flush: count=4 and flush_i=1 with concurrent push of 2 -> next cycle all valids 0, count=0, pushed instructions absent.
